// File: rtl/pmem_req_scheduler.sv
// Arbitrates instruction-cache reads, data-cache reads and write-buffer writes onto one
// line-granular memory port, with write aging and read-after-write line hazard forcing.
module pmem_req_scheduler #(
    parameter int AGE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_read,
    input  logic [31:0]  i_addr,
    output logic         i_resp,
    output logic [255:0] i_rdata,
    input  logic         d_read,
    input  logic [31:0]  d_addr,
    output logic         d_resp,
    output logic [255:0] d_rdata,
    input  logic         w_write,
    input  logic [31:0]  w_addr,
    input  logic [255:0] w_wdata,
    output logic         w_resp,
    output logic         mem_read,
    output logic         mem_write,
    output logic [31:0]  mem_address,
    output logic [255:0] mem_wdata,
    input  logic [255:0] mem_rdata,
    input  logic         mem_resp
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, GNT_W} state_e;

    localparam logic [3:0] AGE_MAX = 4'(AGE_LIMIT);

    state_e     state_q, state_d;
    logic [3:0] w_age_q, w_age_d;
    logic       age_forced;
    logic       line_hazard;

    // Byte offsets within a line never reach the memory port.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{i_addr[4:0], d_addr[4:0], w_addr[4:0]};

    assign age_forced  = w_write && (w_age_q == AGE_MAX);
    assign line_hazard = w_write && d_read && (w_addr[31:5] == d_addr[31:5]);

    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

    always_comb begin
        state_d     = state_q;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = 32'h0;
        mem_wdata   = 256'h0;
        i_resp      = 1'b0;
        d_resp      = 1'b0;
        w_resp      = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A starved write or a pending read of the line being written goes first.
                if (age_forced || line_hazard) state_d = GNT_W;
                else if (d_read)               state_d = GNT_D;
                else if (i_read)               state_d = GNT_I;
                else if (w_write)              state_d = GNT_W;
            end
            GNT_I: begin
                mem_read    = 1'b1;
                mem_address = {i_addr[31:5], 5'b0};
                if (mem_resp) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                mem_read    = 1'b1;
                mem_address = {d_addr[31:5], 5'b0};
                if (mem_resp) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            GNT_W: begin
                mem_write   = 1'b1;
                mem_address = {w_addr[31:5], 5'b0};
                mem_wdata   = w_wdata;
                if (mem_resp) begin
                    w_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // w_age counts read completions a pending write has had to sit through.
    always_comb begin
        w_age_d = w_age_q;
        if (!w_write) begin
            w_age_d = 4'd0;
        end else if (mem_resp && state_q == GNT_W) begin
            w_age_d = 4'd0;
        end else if (mem_resp && (state_q == GNT_I || state_q == GNT_D)
                     && w_age_q < AGE_MAX) begin
            w_age_d = w_age_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            w_age_q <= 4'd0;
        end else begin
            state_q <= state_d;
            w_age_q <= w_age_d;
        end
    end

endmodule

// File: tb/tb_pmem_req_scheduler.sv
// Bench for pmem_req_scheduler: vector table, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_pmem_req_scheduler;

    localparam int AGE = 2;
    localparam int NONE = 0, RQ_I = 1, RQ_D = 2, RQ_W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_read, d_read, w_write, mem_resp;
    logic [31:0]  i_addr, d_addr, w_addr;
    logic [255:0] w_wdata, mem_rdata;
    logic         i_resp, d_resp, w_resp, mem_read, mem_write;
    logic [255:0] i_rdata, d_rdata, mem_wdata;
    logic [31:0]  mem_address;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmem_req_scheduler #(.AGE_LIMIT(AGE)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
        .d_read(d_read), .d_addr(d_addr), .d_resp(d_resp), .d_rdata(d_rdata),
        .w_write(w_write), .w_addr(w_addr), .w_wdata(w_wdata), .w_resp(w_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    typedef struct {
        logic        ir, dr, ww, mr;
        logic        er, ew;
        logic [31:0] ea;
        logic        eir, edr, ewr;
    } vec_t;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic er, input logic ew,
                           input logic [31:0] ea, input logic [255:0] ewd,
                           input logic eir, input logic edr, input logic ewr);
        chk({tag, ".mem_read"}, 256'(mem_read), 256'(er));
        chk({tag, ".mem_write"}, 256'(mem_write), 256'(ew));
        chk({tag, ".mem_address"}, 256'(mem_address), 256'(ea));
        if (!er) chk({tag, ".mem_wdata"}, mem_wdata, ewd);
        chk({tag, ".i_resp"}, 256'(i_resp), 256'(eir));
        chk({tag, ".d_resp"}, 256'(d_resp), 256'(edr));
        chk({tag, ".w_resp"}, 256'(w_resp), 256'(ewr));
        if (eir) chk({tag, ".i_rdata"}, i_rdata, mem_rdata);
        if (edr) chk({tag, ".d_rdata"}, d_rdata, mem_rdata);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_read = 0; d_read = 0; w_write = 0; mem_resp = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One transaction: a select cycle with no downstream activity, `waits`
    // grant cycles without mem_resp, then the responding cycle.
    task automatic txn(input string tag, input int who, input int waits, input logic [31:0] ea);
        mem_resp = 1'b0;
        @(negedge clk);
        chk_bus({tag, ".sel"}, 0, 0, 32'h0, 256'h0, 0, 0, 0);
        tick();
        for (int k = 0; k <= waits; k++) begin
            mem_resp  = (k == waits);
            mem_rdata = {8{$urandom}};
            @(negedge clk);
            chk_bus(tag, who != RQ_W, who == RQ_W, ea, (who == RQ_W) ? w_wdata : 256'h0,
                    who == RQ_I && mem_resp, who == RQ_D && mem_resp, who == RQ_W && mem_resp);
            tick();
        end
        mem_resp = 1'b0;
    endtask

    // Reference model: which requester owns the port, and how long the write has waited.
    int m_owner, m_age;

    function automatic int pick();
        int order[3] = '{RQ_D, RQ_I, RQ_W};
        logic req[4];
        req[RQ_I] = i_read; req[RQ_D] = d_read; req[RQ_W] = w_write; req[NONE] = 0;
        if (w_write && (m_age == AGE || (d_read && (w_addr >> 5) == (d_addr >> 5))))
            return RQ_W;
        foreach (order[k]) if (req[order[k]]) return order[k];
        return NONE;
    endfunction

    function automatic logic [31:0] rand_addr();
        return 32'h0000_1000 + 32'($urandom_range(0, 255));
    endfunction

    vec_t tbl[10];

    initial begin
        logic pi, pd, pw;
        logic [31:0] ea;
        logic        eresp;
        rst = 1'b0; i_addr = 0; d_addr = 0; w_addr = 0;
        w_wdata = {8{32'hA5A5_0F0F}}; mem_rdata = 0;
        clear_inputs();

        // Priority table: all three request, each drops after its response.
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 1'b0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0};

        do_reset();
        @(negedge clk);
        chk_bus("reset", 0, 0, 32'h0, 256'h0, 0, 0, 0);
        tick();

        i_addr = 32'h0000_0104; d_addr = 32'h0000_0208; w_addr = 32'h0000_031C;
        foreach (tbl[r]) begin
            i_read = tbl[r].ir; d_read = tbl[r].dr; w_write = tbl[r].ww; mem_resp = tbl[r].mr;
            mem_rdata = {8{$urandom}};
            @(negedge clk);
            chk_bus($sformatf("prio[%0d]", r), tbl[r].er, tbl[r].ew, tbl[r].ea,
                    tbl[r].ew ? w_wdata : 256'h0, tbl[r].eir, tbl[r].edr, tbl[r].ewr);
            tick();
        end

        // Aging: reads always pending, write forced after AGE read completions.
        do_reset();
        i_read = 1; d_read = 1; w_write = 1;
        txn("age.d1", RQ_D, 0, 32'h200);
        txn("age.d2", RQ_D, 1, 32'h200);
        txn("age.w1", RQ_W, 0, 32'h300);
        txn("age.d3", RQ_D, 0, 32'h200);
        txn("age.d4", RQ_D, 0, 32'h200);
        txn("age.w2", RQ_W, 2, 32'h300);
        clear_inputs();

        // Hazard: same line written and read.
        do_reset();
        w_addr = 32'h0000_1040; d_addr = 32'h0000_1058; w_write = 1; d_read = 1;
        txn("haz.w", RQ_W, 0, 32'h0000_1040);
        w_write = 0;
        txn("haz.d", RQ_D, 0, 32'h0000_1040);
        d_read = 0;

        // Handshake: response delayed five cycles.
        i_addr = 32'h0000_2004; i_read = 1;
        txn("hs", RQ_I, 5, 32'h0000_2000);
        i_read = 0;
        @(negedge clk);
        chk_bus("hs.after", 0, 0, 32'h0, 256'h0, 0, 0, 0);
        tick();

        // Reset in the middle of a data read.
        d_addr = 32'h0000_3000; d_read = 1;
        @(negedge clk);
        chk_bus("rst.sel", 0, 0, 32'h0, 256'h0, 0, 0, 0);
        tick();
        @(negedge clk);
        chk_bus("rst.gnt", 1, 0, 32'h3000, 256'h0, 0, 0, 0);
        tick();
        rst = 1;
        tick();
        rst = 0; d_read = 0; mem_resp = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk_bus($sformatf("rst.late%0d", k), 0, 0, 32'h0, 256'h0, 0, 0, 0);
            tick();
        end

        // Spurious responses in IDLE, then a normal grant with 1-cycle latency.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk_bus($sformatf("spur%0d", k), 0, 0, 32'h0, 256'h0, 0, 0, 0);
            tick();
        end
        i_addr = 32'h0000_0047; i_read = 1;
        txn("spur.i", RQ_I, 0, 32'h0000_0040);
        i_read = 0;

        // Randomized traffic against the reference model.
        do_reset();
        m_owner = NONE; m_age = 0; pi = 0; pd = 0; pw = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!pi && $urandom_range(0, 3) == 0) begin pi = 1; i_addr = rand_addr(); end
            if (!pd && $urandom_range(0, 3) == 0) begin pd = 1; d_addr = rand_addr(); end
            if (!pw && $urandom_range(0, 4) == 0) begin
                pw = 1; w_addr = rand_addr(); w_wdata = {8{$urandom}};
            end
            i_read = pi; d_read = pd; w_write = pw;
            rst = ($urandom_range(0, 199) == 0);
            mem_resp = ($urandom_range(0, 9) < 4);
            mem_rdata = {8{$urandom}};
            @(negedge clk);
            case (m_owner)
                RQ_I:    ea = i_addr & 32'hFFFF_FFE0;
                RQ_D:    ea = d_addr & 32'hFFFF_FFE0;
                RQ_W:    ea = w_addr & 32'hFFFF_FFE0;
                default: ea = 32'h0;
            endcase
            eresp = mem_resp && m_owner != NONE;
            chk_bus($sformatf("rand[%0d]", c), m_owner == RQ_I || m_owner == RQ_D,
                    m_owner == RQ_W, ea, (m_owner == RQ_W) ? w_wdata : 256'h0,
                    eresp && m_owner == RQ_I, eresp && m_owner == RQ_D,
                    eresp && m_owner == RQ_W);
            if (eresp && m_owner == RQ_I) pi = 0;
            if (eresp && m_owner == RQ_D) pd = 0;
            if (eresp && m_owner == RQ_W) pw = 0;
            if (rst) begin
                m_owner = NONE; m_age = 0;
            end else begin
                if (!w_write || (eresp && m_owner == RQ_W)) m_age = 0;
                else if (eresp) m_age = (m_age + 1 > AGE) ? AGE : m_age + 1;
                if (m_owner == NONE) m_owner = pick();
                else if (eresp) m_owner = NONE;
            end
            tick();
        end
        rst = 0;
        clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
